// File: rtl/fp_pkg.sv
// Shared constants and types for the IEEE-754 single <-> Q16.16 converters.
package fp_pkg;

  localparam int          EXP_BIAS  = 127;
  localparam int          FRAC_BITS = 16;
  localparam int          MANT_BITS = 23;
  localparam logic [31:0] FIX_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] FIX_MIN   = 32'h8000_0000;

  // Exponent at which {1,mantissa} already sits at the Q16.16 binary point.
  localparam logic [7:0] EXP_UNITY = 8'(EXP_BIAS + MANT_BITS - FRAC_BITS);
  localparam logic [7:0] EXP_SAT   = EXP_UNITY + 8'd8;
  localparam logic [7:0] EXP_TINY  = EXP_UNITY - 8'd23;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic        sign;
    fp_class_e   cls;
    logic        unf;
    logic        shl;
    logic [4:0]  shamt;
    logic [23:0] sig;
  } s1_t;

  typedef struct packed {
    logic [31:0] fixed;
    logic        ovf;
    logic        unf;
    logic        nan;
    logic        inexact;
  } res_t;

  function automatic fp_class_e classify(input logic [7:0] e, input logic [22:0] m);
    if (e == 8'd0)        return ZERO;
    else if (e == 8'hFF)  return (m != '0) ? NAN : INF;
    else                  return NORMAL;
  endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// One valid/ready pipeline register; holds its contents while the consumer stalls.
module fp_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             full;
  logic [WIDTH-1:0] data;

  assign in_ready  = !full || out_ready;
  assign out_valid = full;
  assign out_data  = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_ready) begin
      full <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/fp_decoder.sv
// IEEE-754 single to signed Q16.16 converter, two-stage valid/ready pipeline.
module fp_decoder
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ieee754,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fixed,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_nan,
  output logic        out_inexact
);

  logic        sign;
  logic [7:0]  expo;
  logic [22:0] mant;

  s1_t  s1_d, s1_q;
  res_t s2_d, s2_q;
  logic s1_in_ready, s1_valid, s2_in_ready;

  assign sign = in_ieee754[31];
  assign expo = in_ieee754[30:23];
  assign mant = in_ieee754[22:0];

  // Stage 1: classify and pick shift direction/amount. Saturating normals
  // are folded into INF and out-of-range tiny normals into ZERO.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign;
    s1_d.sig  = {1'b1, mant};
    s1_d.cls  = classify(expo, mant);
    if (s1_d.cls == ZERO) begin
      s1_d.unf = |mant;
    end else if (s1_d.cls == NORMAL) begin
      if (expo < EXP_TINY) begin
        s1_d.cls = ZERO;
        s1_d.unf = 1'b1;
      end else if (expo > EXP_SAT || (expo == EXP_SAT && !(sign && mant == '0))) begin
        s1_d.cls = INF;
      end else if (expo >= EXP_UNITY) begin
        s1_d.shl   = 1'b1;
        s1_d.shamt = 5'(expo - EXP_UNITY);
      end else begin
        s1_d.shamt = 5'(EXP_UNITY - expo);
      end
    end
  end

  fp_pipe_stage #(.WIDTH($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (s1_d),
    .in_ready  (s1_in_ready),
    .out_valid (s1_valid),
    .out_data  (s1_q),
    .out_ready (s2_in_ready)
  );

  assign in_ready = s1_in_ready && !rst;

  logic [31:0] wide, mag;
  logic [23:0] mask;
  logic        lost;

  // Stage 2: shift, negate, saturate.
  always_comb begin
    s2_d = '0;
    wide = {8'b0, s1_q.sig};
    mag  = s1_q.shl ? (wide << s1_q.shamt) : (wide >> s1_q.shamt);
    mask = (24'd1 << s1_q.shamt) - 24'd1;
    lost = !s1_q.shl && (|(s1_q.sig & mask));
    case (s1_q.cls)
      ZERO: begin
        s2_d.unf     = s1_q.unf;
        s2_d.inexact = s1_q.unf;
      end
      NAN: s2_d.nan = 1'b1;
      INF: begin
        s2_d.fixed = s1_q.sign ? FIX_MIN : FIX_MAX;
        s2_d.ovf   = 1'b1;
      end
      default: begin
        s2_d.fixed   = s1_q.sign ? (~mag + 32'd1) : mag;
        s2_d.inexact = lost;
      end
    endcase
  end

  fp_pipe_stage #(.WIDTH($bits(res_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_data   (s2_d),
    .in_ready  (s2_in_ready),
    .out_valid (out_valid),
    .out_data  (s2_q),
    .out_ready (out_ready)
  );

  assign out_fixed   = s2_q.fixed;
  assign out_ovf     = s2_q.ovf;
  assign out_unf     = s2_q.unf;
  assign out_nan     = s2_q.nan;
  assign out_inexact = s2_q.inexact;

endmodule

// File: doc/fp_decoder.md
FP_DECODER -- requirements
Module: fp_decoder

Interface
REQ-001 The block SHALL have no parameters; Q16.16 output format and IEEE-754 single input format are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_ieee754 holds a word to convert.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_ieee754  input  32  IEEE-754 single: sign[31], exp[30:23], mantissa[22:0].
REQ-007 out_valid  output  1  out_fixed and flags are valid.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_fixed  output  32  signed two's-complement Q16.16 result.
REQ-010 out_ovf, out_unf, out_nan, out_inexact  output  1 each  saturation, underflow-to-zero, NaN input, precision lost.

Function
REQ-011 A transfer SHALL occur on an edge where valid and ready are both high, on either side.
REQ-012 The datapath SHALL be a 2-stage pipeline: S1 registers classify/shift-amount, S2 registers shift/negate/saturate; latency accept-to-out_valid exactly 2 cycles with no stall.
REQ-013 in_ready SHALL equal !S1_full || S1 advances; S1 advances when !S2_full || out_ready; full throughput 1 word/cycle.
REQ-014 While out_valid && !out_ready, out_fixed and all flags SHALL hold stable.
REQ-015 Accept and output transfer in the same cycle SHALL both complete with no loss, duplication or reordering.
REQ-016 E=0 (zero/denormal): result 0; out_unf=out_inexact=1 iff mantissa!=0.
REQ-017 E=255, mantissa!=0: result 0, out_nan=1, other flags 0.
REQ-018 E=255, mantissa=0: +inf -> 0x7FFFFFFF, -inf -> 0x80000000, out_ovf=1.
REQ-019 Normal: magnitude = {1,mantissa} shifted by s=E-134; s>=0 left shift, s<0 right shift by -s, truncating toward zero.
REQ-020 E>=142 SHALL saturate (0x7FFFFFFF positive, 0x80000000 negative) with out_ovf=1, except sign=1,E=142,mantissa=0 -> 0x80000000 exact, no flags.
REQ-021 E<111 SHALL give 0 with out_unf=1, out_inexact=1.
REQ-022 out_inexact SHALL be 1 when any nonzero bit is discarded by the right shift.
REQ-023 sign=1 SHALL produce two's complement of the magnitude; -0 SHALL produce 0x00000000.
REQ-024 Flags SHALL be per-result, not sticky.

Reset
REQ-025 rst high SHALL clear S1/S2 valid, out_valid=0, out_fixed=0x00000000, all flags 0 on the next edge.
REQ-026 in_ready SHALL be 0 while rst is high; words in flight at reset SHALL be discarded and never emitted.
REQ-027 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-028 Shared package fp_pkg SHALL hold EXP_BIAS=127, FRAC_BITS=16, FIX_MAX=0x7FFFFFFF, FIX_MIN=0x80000000 and the class enum {ZERO, NORMAL, INF, NAN}; the existing encoder SHALL use the same constants.
REQ-029 Pipeline-register/handshake logic SHALL be one sub-module fp_pipe_stage, instantiated twice; shift/classify logic inline.

Verification
REQ-030 0x3F800000 accepted, out_ready=1 -> 2 cycles later out_fixed=0x00010000, all flags 0.
REQ-031 0xC0490FDB -> out_fixed=0xFFFCDBC1, out_inexact=1, others 0.
REQ-032 0x47000000 -> 0x7FFFFFFF, out_ovf=1; 0xC7000000 -> 0x80000000, no flags; 0xFF800000 -> 0x80000000, out_ovf=1.
REQ-033 0x7FC00000 -> 0, out_nan=1; 0x33800000 -> 0, out_unf=1, out_inexact=1; 0x80000000 -> 0, no flags.
REQ-034 3 words offered back-to-back, out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, output stable; on out_ready=1 all 3 emerge in order, once each.
REQ-035 rst pulsed 1 cycle with both stages full -> out_valid=0 next cycle, no stale result afterwards; next accepted 0x3F800000 -> 0x00010000.
